// File: rtl/spi_router.sv
// spi_router
// Routes one primary SPI master to one of NCH slave channels. The active
// channel is programmed through a slow debug SPI port (mode 0, MSB first)
// that is oversampled in the clk domain. A selection change made while the
// primary ss is active is parked as "pending" and applied once ss is idle.
// Each channel has a saturating transaction counter readable over debug.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   debug_ss/sclk/mosi debug SPI inputs (asynchronous, synchronised here)
//   debug_miso        debug reply bit, 0 while debug_ss is idle
//   ss, sclk, mosi    primary SPI from the master
//   miso              primary return data (from the selected channel)
//   dev_ss/sclk/mosi  per-channel SPI outputs
//   dev_miso          per-channel return data
//   pending           a selection change is waiting for ss to go idle
module spi_router #(
    parameter int          NCH       = 4,
    parameter logic [15:0] MISO_MASK = 16'h0003,
    parameter int          CNTW      = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           debug_ss,
    input  logic           debug_sclk,
    input  logic           debug_mosi,
    output logic           debug_miso,
    input  logic           ss,
    input  logic           sclk,
    input  logic           mosi,
    output logic           miso,
    output logic [NCH-1:0] dev_ss,
    output logic [NCH-1:0] dev_sclk,
    output logic [NCH-1:0] dev_mosi,
    input  logic [NCH-1:0] dev_miso,
    output logic           pending
);
    localparam logic [4:0]      NCH5    = 5'(NCH);
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    // Synchronisers plus one extra stage per edge-detected signal.
    logic r_dss_s1, r_dss_s2, r_dss_d;
    logic r_dsck_s1, r_dsck_s2, r_dsck_d;
    logic r_dmosi_s1, r_dmosi_s2;
    logic r_ss_s1, r_ss_s2, r_ss_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dss_s1   <= 1'b1;
            r_dss_s2   <= 1'b1;
            r_dss_d    <= 1'b1;
            r_dsck_s1  <= 1'b0;
            r_dsck_s2  <= 1'b0;
            r_dsck_d   <= 1'b0;
            r_dmosi_s1 <= 1'b0;
            r_dmosi_s2 <= 1'b0;
            r_ss_s1    <= 1'b1;
            r_ss_s2    <= 1'b1;
            r_ss_d     <= 1'b1;
        end else begin
            r_dss_s1   <= debug_ss;
            r_dss_s2   <= r_dss_s1;
            r_dss_d    <= r_dss_s2;
            r_dsck_s1  <= debug_sclk;
            r_dsck_s2  <= r_dsck_s1;
            r_dsck_d   <= r_dsck_s2;
            r_dmosi_s1 <= debug_mosi;
            r_dmosi_s2 <= r_dmosi_s1;
            r_ss_s1    <= ss;
            r_ss_s2    <= r_ss_s1;
            r_ss_d     <= r_ss_s2;
        end
    end

    logic w_dss_fall, w_dss_rise, w_dsck_rise, w_dsck_fall, w_ss_fall;
    assign w_dss_fall  = r_dss_d & ~r_dss_s2;
    assign w_dss_rise  = ~r_dss_d & r_dss_s2;
    // debug clock edges only count while the debug port is selected
    assign w_dsck_rise = ~r_dsck_d & r_dsck_s2 & ~r_dss_s2;
    assign w_dsck_fall = r_dsck_d & ~r_dsck_s2 & ~r_dss_s2;
    assign w_ss_fall   = r_ss_d & ~r_ss_s2;

    // Frame assembly. The 3-bit counter wraps to 0 after 8 bits, so a
    // nonzero count at a debug_ss rise always means a partial frame.
    logic [2:0] r_bitcnt;
    logic [7:0] r_shift;
    logic       r_frame_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bitcnt     <= '0;
            r_shift      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_dss_fall || w_dss_rise) begin
                r_bitcnt <= '0;
            end else if (w_dsck_rise) begin
                r_shift      <= {r_shift[6:0], r_dmosi_s2};
                r_bitcnt     <= r_bitcnt + 3'd1;
                r_frame_done <= (r_bitcnt == 3'd7);
            end
        end
    end

    // Control state
    logic       r_en, r_pending, r_tgt_en, r_err;
    logic [3:0] r_sel, r_tgt_sel;
    logic [7:0] r_reply;

    logic       w_en_next, w_pending_next, w_tgt_en_next, w_err_next;
    logic [3:0] w_sel_next, w_tgt_sel_next;
    logic [7:0] w_reply_next;
    logic       w_apply, w_idx_ok, w_is_select, w_sel_en, w_reply_status;
    logic [3:0] w_idx;
    logic       w_clr_cmd;
    logic [16*8-1:0] w_cnt_flat;

    assign w_apply   = r_pending & r_ss_s2;
    assign w_idx     = r_shift[3:0];
    assign w_idx_ok  = {1'b0, w_idx} < NCH5;
    assign w_clr_cmd = r_frame_done && (r_shift[7:4] == 4'h4);

    always_comb begin
        w_en_next      = r_en;
        w_sel_next     = r_sel;
        w_pending_next = r_pending;
        w_tgt_en_next  = r_tgt_en;
        w_tgt_sel_next = r_tgt_sel;
        w_err_next     = r_err;
        w_reply_next   = r_reply;
        w_is_select    = 1'b0;
        w_sel_en       = 1'b0;
        w_reply_status = 1'b1;

        if (w_apply) begin
            w_en_next      = r_tgt_en;
            if (r_tgt_en)
                w_sel_next = r_tgt_sel;
            w_pending_next = 1'b0;
        end

        if (r_frame_done) begin
            case (r_shift[7:4])
                4'h0: begin
                    if (w_idx == 4'h0) begin
                        w_reply_next   = {1'b1, r_en, r_pending, r_err, r_sel};
                        w_reply_status = 1'b0;
                        w_err_next     = 1'b0;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
                4'h1: begin
                    if (w_idx_ok) begin
                        w_is_select = 1'b1;
                        w_sel_en    = 1'b1;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
                4'h2: begin
                    if (w_idx == 4'h0)
                        w_is_select = 1'b1;
                    else
                        w_err_next = 1'b1;
                end
                4'h3: begin
                    if (w_idx_ok) begin
                        w_reply_next   = w_cnt_flat[{w_idx, 3'b000} +: 8];
                        w_reply_status = 1'b0;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
                4'h4: begin
                    // the clear itself is performed by the channel counter
                    if (!w_idx_ok)
                        w_err_next = 1'b1;
                end
                default: w_err_next = 1'b1;
            endcase

            // A select always refreshes the target, so if it lands on the
            // same cycle as a pending apply the pending flag survives one
            // more cycle and re-applies the newer selection.
            if (w_is_select) begin
                w_tgt_en_next = w_sel_en;
                if (w_sel_en)
                    w_tgt_sel_next = w_idx;
                if (r_ss_s2) begin
                    w_en_next      = w_sel_en;
                    if (w_sel_en)
                        w_sel_next = w_idx;
                    w_pending_next = r_pending;
                end else begin
                    w_pending_next = 1'b1;
                end
            end

            if (w_reply_status)
                w_reply_next = {1'b1, w_en_next, w_pending_next, w_err_next, w_sel_next};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_en      <= 1'b0;
            r_sel     <= '0;
            r_pending <= 1'b0;
            r_tgt_en  <= 1'b0;
            r_tgt_sel <= '0;
            r_err     <= 1'b0;
            r_reply   <= 8'h80;
        end else begin
            r_en      <= w_en_next;
            r_sel     <= w_sel_next;
            r_pending <= w_pending_next;
            r_tgt_en  <= w_tgt_en_next;
            r_tgt_sel <= w_tgt_sel_next;
            r_err     <= w_err_next;
            r_reply   <= w_reply_next;
        end
    end

    // Reply shifter: bit (7 - count) is next on the wire, so the fall after
    // the 8th rise presents the MSB of the freshly loaded reply.
    logic r_dmiso;
    always_ff @(posedge clk) begin
        if (reset)
            r_dmiso <= 1'b0;
        else if (r_dss_s2)
            r_dmiso <= 1'b0;
        else if (w_dss_fall)
            r_dmiso <= r_reply[7];
        else if (w_dsck_fall)
            r_dmiso <= r_reply[~r_bitcnt];
    end
    assign debug_miso = r_dmiso;

    // Per-channel routing and counters, zero-padded to 16 channels so the
    // 4-bit selection can index them directly.
    logic [15:0] w_miso_ext;

    for (genvar gi = 0; gi < 16; gi++) begin : g_ch
        if (gi < NCH) begin : g_on
            logic [CNTW-1:0] r_cnt;
            always_ff @(posedge clk) begin
                if (reset)
                    r_cnt <= '0;
                else if (w_clr_cmd && (r_shift[3:0] == 4'(gi)))
                    r_cnt <= '0;
                else if (w_ss_fall && r_en && (r_sel == 4'(gi)) && (r_cnt != CNT_MAX))
                    r_cnt <= r_cnt + 1'b1;
            end
            assign w_cnt_flat[gi*8 +: 8] = 8'(r_cnt);
            assign w_miso_ext[gi]        = dev_miso[gi] & MISO_MASK[gi];
            assign dev_ss[gi]            = (r_en && (r_sel == 4'(gi))) ? ss : 1'b1;
            assign dev_sclk[gi]          = sclk;
            assign dev_mosi[gi]          = mosi;
        end else begin : g_off
            assign w_cnt_flat[gi*8 +: 8] = 8'h00;
            assign w_miso_ext[gi]        = 1'b0;
        end
    end

    assign miso    = r_en & w_miso_ext[r_sel];
    assign pending = r_pending;

endmodule

// File: doc/spi_router.md
# spi_router

Parametrised SPI router with a built-in debug command port. It connects one primary SPI master to one of `NCH` slave devices, such as ADCs and DACs. Selection is programmed over a low-speed debug SPI port that the block oversamples in the system clock domain. A selection change never cuts into a live primary transaction: it is held pending until the primary `ss` goes idle. The block also keeps a per-channel transaction counter and reports status and counts over the debug port.

## Interface
Parameters:
- `NCH`, 4: number of slave channels, 1..16.
- `MISO_MASK`, 4'b0011: bit n set means channel n drives MISO. Channels with the bit clear are write-only, and `miso` reads 0 while one of them is selected.
- `CNTW`, 8: transaction counter width, 1..8. Counters saturate.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `debug_ss`  in  1  debug chip select, active low.
- `debug_sclk`  in  1  debug clock, SPI mode 0.
- `debug_mosi`  in  1  debug data in, MSB first.
- `debug_miso`  out  1  debug data out.
- `ss`  in  1  primary chip select, active low.
- `sclk`  in  1  primary clock.
- `mosi`  in  1  primary data.
- `miso`  out  1  primary return data.
- `dev_ss`  out  NCH  per-channel chip select, active low.
- `dev_sclk`  out  NCH  per-channel clock (fanout of `sclk`).
- `dev_mosi`  out  NCH  per-channel data (fanout of `mosi`).
- `dev_miso`  in  NCH  per-channel return data.
- `pending`  out  1  a selection change is waiting for `ss` to go idle.

## Operation
**Debug port input sampling**
- `debug_ss`, `debug_sclk` and `debug_mosi` each pass through a 2-FF synchronizer.
- Edges are detected on the synchronized signals.
- `debug_mosi` is sampled on the synchronized rising edge of `debug_sclk`.
- A 3-bit counter assembles 8-bit frames.

**Frame handling**
- A frame completes on the 8th rising edge. The command executes in the following cycle.
- If `debug_ss` rises with a bit count other than 0 or 8, the frame is discarded: no command executes and the counter clears.
- The bit counter also clears on every `debug_ss` fall.

**Reply path**
- The reply register is loaded when each command executes.
- The reply is shifted out during the next frame, MSB first.
- The MSB is driven when synchronized `debug_ss` falls. Each subsequent bit is driven on synchronized `debug_sclk` falling edges.
- `debug_miso` is 0 while `debug_ss` is high.

**Status byte:** {1, en, pending, err, sel[3:0]}.

**Commands**
- **0x00, status:** reply = status. `err` clears after the reply is captured.
- **0x1n, select channel n.**
  - If n ≥ NCH: set `err`, selection unchanged.
  - If synchronized `ss` is high: sel=n and en=1 immediately.
  - Otherwise: store n as the pending target and set `pending`. A later select overwrites the pending target.
- **0x20, deselect all.** Same deferral rule as select; the applied result is en=0.
- **0x3n, read count n.**
  - If n < NCH: reply = count[n], zero-extended to 8 bits.
  - Otherwise: set `err` and reply = status.
- **0x4n, clear count n.**
  - If n < NCH: count[n] is set to 0.
  - Otherwise: set `err`.
- **Any other byte:** set `err`.
- **Reply content:** for every command except 0x00 and valid 0x3n, the reply is the status byte after execution.

**Pending apply**
- Checked every cycle.
- If `pending` is set and synchronized `ss` is high, apply the target and clear `pending`.

**Primary path (combinational from registered state)**
- `dev_ss[k]` = `ss` when en and sel==k, else 1.
- `dev_sclk[k]` = `sclk` and `dev_mosi[k]` = `mosi` for every k.
- `miso` = `dev_miso[sel]` when en and MISO_MASK[sel], else 0.

**Counters**
- On each falling edge of synchronized `ss` while en=1, count[sel] increments.
- Counters saturate at 2^CNTW−1.
- If an increment and a clear of the same channel occur in the same cycle, the clear wins.

## Timing
- **Reset values:**
  - en=0, sel=0, `pending`=0, `err`=0, all counters 0.
  - Reply register = 0x80.
  - All `dev_ss` = 1, `miso` = 0, `debug_miso` = 0.
- **Reset mid-frame:** the partial debug frame is lost. `pending` clears and the target is not applied.
- **Debug clock limit:** `debug_sclk` must be ≤ clk/8. Its high and low phases must each be ≥ 3 clk.
- **Command latency:** a command executes 4 clk after the 8th raw rising edge of `debug_sclk` (2 sync + 1 edge detect + 1 execute).
- **Immediate select:** with `ss` idle, `dev_ss` gating changes 1 clk after execute.
- **Deferred select:** the target is applied 3 clk after raw `ss` rises (2 sync + 1 apply).
- **Simultaneous events:**
  - If a select executes in the same cycle that synchronized `ss` falls, the command sees `ss` low and defers.
  - If the pending apply and a new select command coincide, the new command wins and `pending` stays set.
- **Back-to-back frames:** `debug_ss` may stay low across multiple frames. Each 8 bits is a frame, and the reply reloads per frame.

## Test plan
- **Reset and status read:** reset, then debug frame 0x00, then frame 0x00. The 2nd frame shifts out 0x80, and every `dev_ss` stays 1 while `ss` toggles.
- **Immediate select:** with `ss` high, send 0x12, then 0x00. The reply is 0xC2. While `ss` is low, `dev_ss`=4'b1011; with NCH=4 and MISO_MASK=4'b0011, `miso`=0.
- **Deferred select:** hold `ss` low on channel 1 and send 0x10. `pending`=1 and `dev_ss[1]` follows `ss`. Raise `ss`; 3 clk later `pending`=0, and the next `ss` low drives `dev_ss[0]` only.
- **Counter saturation and clear:** with CNTW=2 on channel 0, run 5 `ss` pulses, then send 0x30 and read: reply 0x03. Then send 0x40 and 0x30 and read: reply 0x00.
- **Error handling:** with NCH=4, send 0x17, then 0x00 and read. The 0x00 reply has err=1 and the selection is unchanged. A further 0x00 reads back err=0.
- **Aborted frame:** drop `debug_ss` after 5 bits of 0x13. No select occurs, and the next full 0x00 frame executes normally.
